pc_fetch_unit: RTL and testbench

- Program counter and instruction register stage that feeds the control FSM.
- Consumes the FSM's PC controls (pc_en, pc_mux_selct, pc_add_k) and the load/store address select.
- Drives the RAM port-A address, captures the synchronous-read RAM output as the current instruction, and presents it to the FSM and decoder as instr_set.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/fetch_stats.sv | 28 ++
 rtl/pc_fetch_unit.sv | 88 ++++++++
 tb/tb_pc_fetch_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: bus widths, reset PC, NOP encoding, branch displacement width.
// Latency: none (package only).
// Backpressure: not applicable.
package cpu_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;
    localparam int RESET_PC_DEF = 0;
    localparam int DISP_W = 8;

    // All-zero word decodes as WAIT; used as the IR value out of reset.
    localparam logic [15:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/fetch_stats.sv
// Saturating retire / taken-branch counters for the fetch unit.
// Latency: counts visible one cycle after the retiring pc_en cycle.
// Backpressure: none; counters stick at all-ones instead of wrapping.
module fetch_stats (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_en,
    input  logic        pc_mux_selct,
    output logic [15:0] retired_cnt,
    output logic [15:0] taken_cnt
);

    // Count retires and taken branches, holding at 16'hFFFF once reached.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired_cnt <= '0;
            taken_cnt   <= '0;
        end else if (pc_en) begin
            if (retired_cnt != 16'hFFFF) begin
                retired_cnt <= retired_cnt + 16'd1;
            end
            if (pc_mux_selct && (taken_cnt != 16'hFFFF)) begin
                taken_cnt <= taken_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, RAM port-A address mux and instruction register feeding the control FSM.
// Latency: mem_addr combinational; instruction visible (bypass) the cycle after fetch_req.
// Backpressure: none; one-cycle RAM read, back-to-back fetches each captured.
// Optional stats counters are built only when PC_FETCH_STATS_EN is defined.
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                  ADDR_W   = ADDR_W_DEF,
    parameter int                  DATA_W   = DATA_W_DEF,
    parameter logic [ADDR_W-1:0]   RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pc_en,
    input  logic              pc_mux_selct,
    input  logic [DISP_W-1:0] pc_add_k,
    input  logic              lsc_mux_selct,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic              fetch_req,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] instr_set,
    output logic [ADDR_W-1:0] pc,
    output logic              ir_valid,
    output logic [15:0]       retired_cnt,
    output logic [15:0]       taken_cnt
);

    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_disp;
    logic [ADDR_W-1:0] pc_next;
    logic [DATA_W-1:0] ir_q;
    logic              fetch_pending;

    // Sign-extend the branch displacement and pick the next PC (modulo 2^ADDR_W).
    always_comb begin
        pc_disp = {{(ADDR_W-DISP_W){pc_add_k[DISP_W-1]}}, pc_add_k};
        pc_next = pc_mux_selct ? (pc_q + pc_disp) : (pc_q + PC_ONE);
    end

    // Program counter: advances only when the FSM asserts pc_en.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else if (pc_en) begin
            pc_q <= pc_next;
        end
    end

    // Fetch pipeline: remember a fetch was issued, then capture RAM data into the IR.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pending <= 1'b0;
            ir_q          <= DATA_W'(NOP_INSTR);
            ir_valid      <= 1'b0;
        end else begin
            fetch_pending <= fetch_req;
            if (fetch_pending) begin
                ir_q     <= ram_dout;
                ir_valid <= 1'b1;
            end
        end
    end

    // Address mux and IR bypass so decode sees the new word in its arrival cycle.
    always_comb begin
        mem_addr  = lsc_mux_selct ? ls_addr : pc_q;
        instr_set = fetch_pending ? ram_dout : ir_q;
        pc        = pc_q;
    end

`ifdef PC_FETCH_STATS_EN
    fetch_stats u_fetch_stats (
        .clk          (clk),
        .reset        (reset),
        .pc_en        (pc_en),
        .pc_mux_selct (pc_mux_selct),
        .retired_cnt  (retired_cnt),
        .taken_cnt    (taken_cnt)
    );
`else
    assign retired_cnt = 16'h0000;
    assign taken_cnt   = 16'h0000;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit; RAM output driven directly by the bench.
// Inputs change 1ns after posedge; outputs sampled at negedge.
// Stats checks depend on whether PC_FETCH_STATS_EN is defined.
module tb_pc_fetch_unit;

    logic        clk;
    logic        reset;
    logic        pc_en;
    logic        pc_mux_selct;
    logic [7:0]  pc_add_k;
    logic        lsc_mux_selct;
    logic [15:0] ls_addr;
    logic        fetch_req;
    logic [15:0] ram_dout;
    logic [15:0] mem_addr;
    logic [15:0] instr_set;
    logic [15:0] pc;
    logic        ir_valid;
    logic [15:0] retired_cnt;
    logic [15:0] taken_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    pc_fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .pc_en         (pc_en),
        .pc_mux_selct  (pc_mux_selct),
        .pc_add_k      (pc_add_k),
        .lsc_mux_selct (lsc_mux_selct),
        .ls_addr       (ls_addr),
        .fetch_req     (fetch_req),
        .ram_dout      (ram_dout),
        .mem_addr      (mem_addr),
        .instr_set     (instr_set),
        .pc            (pc),
        .ir_valid      (ir_valid),
        .retired_cnt   (retired_cnt),
        .taken_cnt     (taken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pc_en = 1'b0; pc_mux_selct = 1'b0; pc_add_k = 8'h00;
        lsc_mux_selct = 1'b0; ls_addr = 16'h0000; fetch_req = 1'b0;
    endtask

    // One retire cycle with the given mux select and displacement.
    task automatic retire(input logic sel, input logic [7:0] k);
        pc_en = 1'b1; pc_mux_selct = sel; pc_add_k = k;
        step();
        pc_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        ram_dout = 16'hDEAD;
        #2 reset = 1'b0;
        @(negedge clk);
        n_checks++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL reset_pc got %h want 0000", pc); end
        n_checks++; if (instr_set !== 16'h0000) begin n_fail++; $display("FAIL reset_instr got %h want 0000", instr_set); end
        n_checks++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ir_valid got %b want 0", ir_valid); end
        n_checks++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_mem_addr got %h want 0000", mem_addr); end
        n_checks++; if (retired_cnt !== 16'h0 || taken_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_counters got %h/%h want 0/0", retired_cnt, taken_cnt); end
        @(posedge clk); #1;
        reset = 1'b1;
        step();
        n_checks++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL idle_pc_hold got %h want 0000", pc); end
    endtask

    task automatic test_fetch();
        // Cycle N: fetch strobe; stale RAM output must not leak to instr_set.
        fetch_req = 1'b1; ram_dout = 16'hDEAD;
        @(negedge clk);
        n_checks++; if (instr_set !== 16'h0000) begin n_fail++; $display("FAIL fetch_no_early_bypass got %h want 0000", instr_set); end
        n_checks++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL fetch_addr got %h want 0000", mem_addr); end
        step();
        // Cycle N+1: RAM returns ADDI, visible combinationally.
        fetch_req = 1'b0; ram_dout = 16'h5312;
        @(negedge clk);
        n_checks++; if (instr_set !== 16'h5312) begin n_fail++; $display("FAIL fetch_bypass got %h want 5312", instr_set); end
        step();
        ram_dout = 16'hBEEF;
        @(negedge clk);
        n_checks++; if (instr_set !== 16'h5312) begin n_fail++; $display("FAIL fetch_hold got %h want 5312", instr_set); end
        n_checks++; if (ir_valid !== 1'b1) begin n_fail++; $display("FAIL fetch_ir_valid got %b want 1", ir_valid); end
        step();
    endtask

    task automatic test_branch();
        retire(1'b1, 8'h10);
        n_checks++; if (pc !== 16'h0010) begin n_fail++; $display("FAIL branch_fwd16 got %h want 0010", pc); end
        retire(1'b1, 8'hFC);
        n_checks++; if (pc !== 16'h000C) begin n_fail++; $display("FAIL branch_neg4 got %h want 000c", pc); end
        retire(1'b1, 8'h05);
        n_checks++; if (pc !== 16'h0011) begin n_fail++; $display("FAIL branch_pos5 got %h want 0011", pc); end
        // pc_en low: select and displacement ignored.
        pc_mux_selct = 1'b1; pc_add_k = 8'h7F;
        step();
        n_checks++; if (pc !== 16'h0011) begin n_fail++; $display("FAIL pc_hold got %h want 0011", pc); end
        retire(1'b0, 8'h7F);
        n_checks++; if (pc !== 16'h0012) begin n_fail++; $display("FAIL pc_inc got %h want 0012", pc); end
    endtask

    task automatic test_wrap();
        retire(1'b1, 8'hEE);
        n_checks++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL branch_to_zero got %h want 0000", pc); end
        retire(1'b1, 8'hFF);
        n_checks++; if (pc !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_down got %h want ffff", pc); end
        retire(1'b0, 8'h00);
        n_checks++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL wrap_up got %h want 0000", pc); end
    endtask

    task automatic test_load_store();
        retire(1'b0, 8'h00);
        retire(1'b0, 8'h00);
        retire(1'b0, 8'h00);
        n_checks++; if (pc !== 16'h0003) begin n_fail++; $display("FAIL ls_pc_setup got %h want 0003", pc); end
        lsc_mux_selct = 1'b1; ls_addr = 16'h0200; pc_en = 1'b1; pc_mux_selct = 1'b0;
        ram_dout = 16'hAAAA;
        @(negedge clk);
        n_checks++; if (mem_addr !== 16'h0200) begin n_fail++; $display("FAIL ls_mem_addr got %h want 0200", mem_addr); end
        step();
        pc_en = 1'b0; ram_dout = 16'hBBBB;
        @(negedge clk);
        n_checks++; if (pc !== 16'h0004) begin n_fail++; $display("FAIL ls_pc_update got %h want 0004", pc); end
        n_checks++; if (instr_set !== 16'h5312) begin n_fail++; $display("FAIL ls_instr_stable got %h want 5312", instr_set); end
        step();
        lsc_mux_selct = 1'b0; ram_dout = 16'hCCCC;
        @(negedge clk);
        n_checks++; if (instr_set !== 16'h5312) begin n_fail++; $display("FAIL ls_instr_stable2 got %h want 5312", instr_set); end
        n_checks++; if (mem_addr !== 16'h0004) begin n_fail++; $display("FAIL ls_addr_back_to_pc got %h want 0004", mem_addr); end
        step();
    endtask

    task automatic test_back_to_back();
        // Fetch and PC advance together: fetch uses old pc 4.
        fetch_req = 1'b1; pc_en = 1'b1; pc_mux_selct = 1'b0;
        @(negedge clk);
        n_checks++; if (mem_addr !== 16'h0004) begin n_fail++; $display("FAIL b2b_old_pc got %h want 0004", mem_addr); end
        step();
        pc_en = 1'b0; ram_dout = 16'h1111;
        @(negedge clk);
        n_checks++; if (instr_set !== 16'h1111) begin n_fail++; $display("FAIL b2b_first got %h want 1111", instr_set); end
        n_checks++; if (mem_addr !== 16'h0005) begin n_fail++; $display("FAIL b2b_new_pc got %h want 0005", mem_addr); end
        step();
        fetch_req = 1'b0; ram_dout = 16'h2222;
        @(negedge clk);
        n_checks++; if (instr_set !== 16'h2222) begin n_fail++; $display("FAIL b2b_second got %h want 2222", instr_set); end
        step();
        ram_dout = 16'h3333;
        @(negedge clk);
        n_checks++; if (instr_set !== 16'h2222) begin n_fail++; $display("FAIL b2b_captured got %h want 2222", instr_set); end
        step();
    endtask

    task automatic test_reset_mid();
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0; ram_dout = 16'h7777;
        @(negedge clk);
        n_checks++; if (instr_set !== 16'h7777) begin n_fail++; $display("FAIL mid_bypass got %h want 7777", instr_set); end
        reset = 1'b0;
        #1;
        n_checks++; if (instr_set !== 16'h0000) begin n_fail++; $display("FAIL mid_reset_instr got %h want 0000", instr_set); end
        n_checks++; if (pc !== 16'h0000 || ir_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_state got pc %h valid %b want 0000 0", pc, ir_valid); end
        step();
        reset = 1'b1;
        step();
        n_checks++; if (instr_set !== 16'h0000) begin n_fail++; $display("FAIL mid_discard got %h want 0000", instr_set); end
    endtask

    task automatic test_stats();
        retire(1'b0, 8'h00);
        retire(1'b1, 8'h01);
        pc_mux_selct = 1'b1;
        step();
        retire(1'b0, 8'h00);
        @(negedge clk);
`ifdef PC_FETCH_STATS_EN
        n_checks++; if (retired_cnt !== 16'd3) begin n_fail++; $display("FAIL stats_retired got %0d want 3", retired_cnt); end
        n_checks++; if (taken_cnt !== 16'd1) begin n_fail++; $display("FAIL stats_taken got %0d want 1", taken_cnt); end
        step();
        pc_en = 1'b1; pc_mux_selct = 1'b0;
        for (int i = 0; i < 65535; i++) step();
        pc_en = 1'b0;
        @(negedge clk);
        n_checks++; if (retired_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL stats_saturate got %h want ffff", retired_cnt); end
        n_checks++; if (taken_cnt !== 16'd1) begin n_fail++; $display("FAIL stats_taken_after got %0d want 1", taken_cnt); end
`else
        n_checks++; if (retired_cnt !== 16'h0000) begin n_fail++; $display("FAIL stats_off_retired got %h want 0000", retired_cnt); end
        n_checks++; if (taken_cnt !== 16'h0000) begin n_fail++; $display("FAIL stats_off_taken got %h want 0000", taken_cnt); end
`endif
        step();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_branch();
        test_wrap();
        test_load_store();
        test_back_to_back();
        test_reset_mid();
        test_stats();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
